// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the bubble encoding, the reset PC default and the fetch FSM states.
package if_stage_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_RUN   = 2'd0,
        IF_STALL = 2'd1,
        IF_REDIR = 2'd2
    } if_state_e;

    // Stall reason codes reported by hazard_data.
    typedef enum logic [1:0] {
        PIP_NONE     = 2'd0,
        PIP_LOAD_USE = 2'd1,
        PIP_MEM_WAIT = 2'd2
    } pip_code_e;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-side bus: instruction ROM port plus the IF/ID register outputs.
// master = if_stage (drives ROM address and IF/ID), slave = ROM/decode side.
interface if_stage_if;
    import if_stage_pkg::*;

    logic [31:0] irom_addr;
    logic [31:0] irom_data;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_inst_o;
    logic        ifid_valid_o;
    logic [4:0]  ifid_rs1_o;
    logic [4:0]  ifid_rs2_o;

    modport master (
        output irom_addr,
        input  irom_data,
        output ifid_pc_o,
        output ifid_inst_o,
        output ifid_valid_o,
        output ifid_rs1_o,
        output ifid_rs2_o
    );

    modport slave (
        input  irom_addr,
        output irom_data,
        input  ifid_pc_o,
        input  ifid_inst_o,
        input  ifid_valid_o,
        input  ifid_rs1_o,
        input  ifid_rs2_o
    );

endinterface

// File: rtl/if_stage_pc_gen.sv
// PC register with next-PC selection and sticky misaligned-target flag.
// Ports: clk, rst, stop, redirect_valid/redirect_pc in; pc, misalign out.
module if_pc_gen
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic        misalign
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else if (redirect_valid) begin
            // Low bits are dropped; the fault is only recorded.
            pc       <= redirect_pc & ~32'd3;
            misalign <= misalign | (redirect_pc[1:0] != 2'b00);
        end else if (!stop) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch plus IF/ID register, fetch FSM and stall/flush counters.
// Ports: clk, rst, pipline_stop, redirect_*, fetch bus (master), misalign, counters.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipline_stop,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    if_stage_if.master       bus,
    output logic             fetch_misalign,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [31:0] pc;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_inst_q;
    logic        ifid_valid_q;
    if_state_e   state_q;
    if_state_e   state_d;

    if_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .stop          (pipline_stop),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .misalign      (fetch_misalign)
    );

    assign bus.irom_addr    = pc;
    assign bus.ifid_pc_o    = ifid_pc_q;
    assign bus.ifid_inst_o  = ifid_inst_q;
    assign bus.ifid_valid_o = ifid_valid_q;
    assign bus.ifid_rs1_o   = ifid_inst_q[19:15];
    assign bus.ifid_rs2_o   = ifid_inst_q[24:20];

    always_comb begin
        state_d = state_q;
        priority case (1'b1)
            redirect_valid: state_d = IF_REDIR;
            pipline_stop:   state_d = IF_STALL;
            default:        state_d = IF_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IF_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_pc_q    <= 32'd0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
        end else if (redirect_valid) begin
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
        end else if (!pipline_stop) begin
            ifid_pc_q    <= pc;
            ifid_inst_q  <= bus.irom_data;
            ifid_valid_q <= 1'b1;
        end
    end

    // Counters stick at all-ones so long runs never read back as small.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (redirect_valid) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (pipline_stop) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
